// File: rtl/onchip_mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// One access is granted per cycle. Read returns are steered back to their
// issuer one cycle after the grant. Out-of-range accesses are absorbed
// (granted but not presented to the RAM) and flagged. Per-master grant
// counters saturate at their maximum value.
module onchip_mem_rr_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 6250,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m0_read,
  input  logic              m1_read,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m0_waitrequest,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m0_readdatavalid,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken,
  output logic              oor_error,
  input  logic              oor_clear,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  m0_grant_cnt,
  output logic [CNT_W-1:0]  m1_grant_cnt
);

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;

  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // Arbiter state
  logic    running_q;   // low until the first edge after reset release
  master_e rr_ptr_q;    // master that wins a tie

  // Read-return pipeline stage
  logic    rd_valid_q;
  master_e rd_owner_q;
  logic    rd_oor_q;

  // Arbitration decision and winner's request fields
  logic              req0, req1;
  logic              grant0, grant1, granted;
  master_e           winner;
  logic [ADDR_W-1:0] win_address;
  logic [BE_W-1:0]   win_byteenable;
  logic [DATA_W-1:0] win_writedata;
  logic              win_write, win_read, win_in_range;

  // Pick at most one requester: a lone requester wins, a tie goes to rr_ptr_q.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (running_q) begin
      if (req0 && (!req1 || rr_ptr_q == M0)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
    granted = grant0 | grant1;
    winner  = grant1 ? M1 : M0;
  end

  // Route the winner's request fields and classify the access.
  always_comb begin
    win_address    = (winner == M1) ? m1_address    : m0_address;
    win_byteenable = (winner == M1) ? m1_byteenable : m0_byteenable;
    win_writedata  = (winner == M1) ? m1_writedata  : m0_writedata;
    win_write      = (winner == M1) ? m1_write      : m0_write;
    // A request with both strobes high is a write; its read is ignored.
    win_read       = ((winner == M1) ? m1_read : m0_read) & ~win_write;
    win_in_range   = ({1'b0, win_address} < ADDR_LIMIT);
  end

  // Drive the RAM port; out-of-range grants never select the RAM.
  always_comb begin
    mem_address    = win_address;
    mem_byteenable = win_byteenable;
    mem_writedata  = win_writedata;
    mem_chipselect = granted & win_in_range;
    mem_write      = granted & win_in_range & win_write;
    mem_clken      = running_q;
  end

  // Master-side handshake and steering of the returned read data.
  always_comb begin
    m0_waitrequest   = ~grant0;
    m1_waitrequest   = ~grant1;
    m0_readdatavalid = rd_valid_q & (rd_owner_q == M0);
    m1_readdatavalid = rd_valid_q & (rd_owner_q == M1);
    m0_readdata      = (m0_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
    m1_readdata      = (m1_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
  end

  // Start-up enable and round-robin pointer: after a grant the other master is favoured.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge regardless of statement order.
    if (!reset_n) begin
      running_q <= 1'b0;
      rr_ptr_q  <= M0;
    end else begin
      running_q <= 1'b1;
      if (granted) begin
        rr_ptr_q <= (winner == M0) ? M1 : M0;
      end
    end
  end

  // Read-return stage: capture the owner of a granted read for next cycle's strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= M0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= granted & win_read;
      rd_owner_q <= winner;
      rd_oor_q   <= ~win_in_range;
    end
  end

  // Sticky out-of-range flag; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_error <= 1'b0;
    end else if (granted && !win_in_range) begin
      oor_error <= 1'b1;
    end else if (oor_clear) begin
      oor_error <= 1'b0;
    end
  end

  // Saturating per-master grant counters; stat_clear overrides counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
    end else if (stat_clear) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
    end else begin
      if (grant0 && m0_grant_cnt != CNT_MAX) begin
        m0_grant_cnt <= m0_grant_cnt + 1'b1;
      end
      if (grant1 && m1_grant_cnt != CNT_MAX) begin
        m1_grant_cnt <= m1_grant_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/onchip_mem_rr_arbiter.md
Name: onchip_mem_rr_arbiter

Overview:
Two-master round-robin arbiter sharing one single-port on-chip RAM (13-bit word address, 32-bit data, 4 byte enables, 1-cycle read latency, no waitrequest of its own). Sits between two Avalon-MM pipelined masters (e.g. CPU data port and a DMA) and the RAM's s1 interface. It grants at most one access per cycle and routes each read return to its issuer. It also guards against out-of-range addresses and keeps per-master grant statistics.

Parameters:
ADDR_W, 13, word address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
NUM_WORDS, 6250, implemented RAM depth; addresses >= NUM_WORDS are out of range
CNT_W, 16, width of saturating grant counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address / m1_address  in  ADDR_W  master word address
m0_byteenable / m1_byteenable  in  BE_W  byte enables
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
m0_readdata / m1_readdata  out  DATA_W  read return data
m0_readdatavalid / m1_readdatavalid  out  1  read return strobe
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  BE_W  RAM byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write
mem_writedata  out  DATA_W  RAM write data
mem_readdata  in  DATA_W  RAM q, valid 1 cycle after address accepted
mem_clken  out  1  RAM clock enable
oor_error  out  1  sticky out-of-range flag
oor_clear  in  1  clears oor_error
stat_clear  in  1  clears grant counters
m0_grant_cnt / m1_grant_cnt  out  CNT_W  saturating accepted-transfer counts

Behaviour:
- Reset (reset_n low, async): waitrequests=1, readdatavalids=0, readdatas=0, mem_chipselect=0, mem_write=0, mem_clken=0, oor_error=0, counters=0, RR pointer favours m0. mem_clken=1 from first clk edge after reset_n rises.
- Request: mN_req = mN_read | mN_write. If both read and write are high, the request is a write (read ignored).
- Arbitration is combinational within the cycle. One requester: it is granted. Both requesting: the pointer holder is granted. After each grant the pointer moves to the other master; with no grant the pointer holds.
- mN_waitrequest = ~grantN. It is high whenever master N is idle or loses arbitration. Transfer completes on the cycle req & ~waitrequest.
- Granted cycle: mem_address/byteenable/writedata/write are muxed from the winner. mem_chipselect=1, mem_write=winner's write.
- Out of range (address >= NUM_WORDS): the grant still occurs (no deadlock) but mem_chipselect=0. A write is dropped. A read returns 0 with normal latency. oor_error sets the next edge. oor_clear clears it; a set in the same cycle as a clear wins.
- Read return: a registered 1-bit valid plus owner tag, captured on grant. The next cycle, owner's readdatavalid=1 and readdata=mem_readdata (0 if the read was OOR). The non-owner's readdata is 0.
- Back-to-back reads (1 per cycle, any mix of masters) are fully pipelined. Returns appear in issue order, exactly 1 cycle after each grant.
- Writes produce no readdatavalid. Read-during-write to the same address in the same cycle cannot occur (single port, one grant per cycle).
- Counters increment on each grant to their master and saturate at 2^CNT_W-1. stat_clear clears both, with priority over increment.
- Reset asserted mid-read: the pending return is discarded (no readdatavalid after reset).

Test Plan:
- Reset: hold reset_n=0, all requests high -> both waitrequests=1, mem_chipselect=0, mem_clken=0. Release -> mem_clken=1 next edge.
- Single master: m0 writes 0xA5A5_1234, be=4'hF, addr 0x10, then reads addr 0x10 -> m0_waitrequest=0 both cycles, m0_readdatavalid=1 one cycle after the read with data 0xA5A5_1234, m1_readdatavalid=0.
- Contention: m0 and m1 continuously read addrs 0x20/0x21 for 6 cycles -> grants alternate m0,m1,m0,…, one readdatavalid per cycle to the alternating owner, each counter=3.
- Byte enables: write 0xFFFFFFFF, then write 0x00000000 with be=4'b0101, read back -> 0xFF00FF00.
- Out of range: m1 writes addr 6250, then reads addr 6250 -> mem_chipselect=0 both cycles, readdata=0 with valid, oor_error=1. oor_clear pulse -> 0.
- Saturation/clear: with CNT_W=4, 20 m0 grants -> m0_grant_cnt=15. stat_clear concurrent with a grant -> 0.
